// File: rtl/sift_frame_sequencer_if.sv
// Handshake bundle between the SIFT frame sequencer and the blur/detect engines.
// The master side is the sequencer; the slave side is the engine array.
interface sift_frame_sequencer_if #(
  parameter int N_SCALES = 4,
  parameter int ROW_W    = 9,
  parameter int CNT_W    = 32
);
  logic                in_valid;
  logic                gauss_row_req;
  logic [ROW_W-1:0]    gauss_row_idx;
  logic [N_SCALES-1:0] gauss_row_ack;
  logic [N_SCALES-1:0] gaussian_done;
  logic                det_start;
  logic                det_done;
  logic                detect_filter_done;
  logic                out_valid;
  logic                err;
  logic [CNT_W-1:0]    cycle_count;

  modport master (
    input  in_valid, gauss_row_ack, det_done,
    output gauss_row_req, gauss_row_idx, gaussian_done, det_start,
           detect_filter_done, out_valid, err, cycle_count
  );

  modport slave (
    output in_valid, gauss_row_ack, det_done,
    input  gauss_row_req, gauss_row_idx, gaussian_done, det_start,
           detect_filter_done, out_valid, err, cycle_count
  );
endinterface

// File: rtl/sift_frame_sequencer.sv
// Frame scheduler: steps all blur engines through the image row by row in lockstep,
// then launches keypoint detection, with a watchdog on every wait state.
module sift_frame_sequencer #(
  parameter int ROWS     = 480,
  parameter int N_SCALES = 4,
  parameter int ROW_W    = 9,
  parameter int TIMEOUT  = 65535,
  parameter int CNT_W    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  sift_frame_sequencer_if.master bus
);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_G_REQ   = 3'd1,
    S_G_NEXT  = 3'd2,
    S_D_START = 3'd3,
    S_D_WAIT  = 3'd4,
    S_DONE    = 3'd5,
    S_ERR     = 3'd6
  } state_t;

  state_t              state_r, state_s;
  logic [ROW_W-1:0]    row_r, row_s;
  logic [N_SCALES-1:0] mask_r, mask_s, merged_s, gdone_r, gdone_s;
  logic [WD_W-1:0]     wd_r, wd_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic                fdone_r, fdone_s;
  logic                wait_s, event_s;
  logic                req_r, dstart_r, ovalid_r, err_r;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // next-state, datapath updates and watchdog
  always_comb begin
    state_s  = state_r;
    row_s    = row_r;
    mask_s   = mask_r;
    gdone_s  = gdone_r;
    fdone_s  = fdone_r;
    wait_s   = 1'b0;
    event_s  = 1'b0;
    merged_s = mask_r | bus.gauss_row_ack;
    if ((state_r inside {S_G_REQ, S_G_NEXT, S_D_START, S_D_WAIT}) && !(&cnt_r)) begin
      cnt_s = cnt_r + CNT_W'(1);
    end else begin
      cnt_s = cnt_r;
    end
    case (state_r)
      S_IDLE: begin
        if (bus.in_valid) begin
          state_s = S_G_REQ;
          row_s   = {ROW_W{1'b0}};
          mask_s  = {N_SCALES{1'b0}};
          gdone_s = {N_SCALES{1'b0}};
          fdone_s = 1'b0;
          cnt_s   = {CNT_W{1'b0}};
        end else begin
          state_s = S_IDLE;
        end
      end
      S_G_REQ: begin
        wait_s  = 1'b1;
        event_s = |(bus.gauss_row_ack & ~mask_r);
        mask_s  = merged_s;
        if (&merged_s) begin
          if (row_r == LAST_ROW) begin
            state_s = S_D_START;
            gdone_s = {N_SCALES{1'b1}};
          end else begin
            state_s = S_G_NEXT;
          end
        end else begin
          state_s = S_G_REQ;
        end
      end
      S_G_NEXT: begin
        row_s   = row_r + {{(ROW_W-1){1'b0}}, 1'b1};
        mask_s  = {N_SCALES{1'b0}};
        state_s = S_G_REQ;
      end
      S_D_START: begin
        if (bus.det_done) begin
          state_s = S_DONE;
          fdone_s = 1'b1;
        end else begin
          state_s = S_D_WAIT;
        end
      end
      S_D_WAIT: begin
        wait_s  = 1'b1;
        event_s = bus.det_done;
        if (bus.det_done) begin
          state_s = S_DONE;
          fdone_s = 1'b1;
        end else begin
          state_s = S_D_WAIT;
        end
      end
      S_DONE: begin
        if (bus.in_valid) begin
          state_s = S_DONE;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ERR: begin
        state_s = S_ERR;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
    // A progress event in the final allowed cycle still beats the timeout.
    if (wait_s && !event_s) begin
      if (wd_r == WD_LIMIT) begin
        state_s = S_ERR;
        wd_s    = {WD_W{1'b0}};
      end else begin
        wd_s = wd_r + WD_W'(1);
      end
    end else begin
      wd_s = {WD_W{1'b0}};
    end
  end

  // datapath registers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_r    <= {ROW_W{1'b0}};
      mask_r   <= {N_SCALES{1'b0}};
      gdone_r  <= {N_SCALES{1'b0}};
      fdone_r  <= 1'b0;
      wd_r     <= {WD_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      req_r    <= 1'b0;
      dstart_r <= 1'b0;
      ovalid_r <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      row_r    <= row_s;
      mask_r   <= mask_s;
      gdone_r  <= gdone_s;
      fdone_r  <= fdone_s;
      wd_r     <= wd_s;
      cnt_r    <= cnt_s;
      req_r    <= (state_s == S_G_REQ);
      dstart_r <= (state_s == S_D_START);
      ovalid_r <= (state_s == S_DONE) && (state_r != S_DONE);
      err_r    <= (state_s == S_ERR);
    end
  end

  assign bus.gauss_row_req      = req_r;
  assign bus.gauss_row_idx      = row_r;
  assign bus.gaussian_done      = gdone_r;
  assign bus.det_start          = dstart_r;
  assign bus.detect_filter_done = fdone_r;
  assign bus.out_valid          = ovalid_r;
  assign bus.err                = err_r;
  assign bus.cycle_count        = cnt_r;
endmodule

// File: tb/tb_sift_frame_sequencer.sv
// Self-checking bench: each frame is planned as per-row ack delays and a detect delay,
// expected waveforms are derived from that plan, then replayed against the sequencer.
module tb_sift_frame_sequencer;
  localparam int ROWS = 4, NS = 4, RW = 2, TO = 16, CW = 32, MAXT = 256;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sift_frame_sequencer_if #(.N_SCALES(NS), .ROW_W(RW), .CNT_W(CW)) bus ();
  sift_frame_sequencer #(.ROWS(ROWS), .N_SCALES(NS), .ROW_W(RW), .TIMEOUT(TO), .CNT_W(CW))
    dut (.clk(clk), .rst(rst), .bus(bus));

  int n_vec = 0, n_bad = 0, cur_t = 0;
  int dly [ROWS][NS];
  int dup [ROWS][NS];
  int det_k, hold;
  bit noise;
  logic [NS-1:0] ack_at [MAXT];
  logic          det_at [MAXT], iv_at [MAXT];
  logic          e_req [MAXT], e_dst [MAXT], e_ov [MAXT], e_err [MAXT], e_fd [MAXT];
  logic [RW-1:0] e_idx [MAXT];
  logic [NS-1:0] e_gd [MAXT];
  logic [CW-1:0] e_cnt [MAXT];
  int t_end, t_ds, t_done, t_err;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", tag, cur_t, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_req"}, bus.gauss_row_req, 0);
    check_val({tag, "_idx"}, bus.gauss_row_idx, 0);
    check_val({tag, "_gd"},  bus.gaussian_done, 0);
    check_val({tag, "_dst"}, bus.det_start, 0);
    check_val({tag, "_fd"},  bus.detect_filter_done, 0);
    check_val({tag, "_ov"},  bus.out_valid, 0);
    check_val({tag, "_err"}, bus.err, 0);
    check_val({tag, "_cnt"}, bus.cycle_count, 0);
  endtask

  task automatic plan_reset(input int d);
    for (int r = 0; r < ROWS; r++)
      for (int s = 0; s < NS; s++) begin
        dly[r][s] = d;
        dup[r][s] = -1;
      end
    det_k = 2; hold = 0; noise = 1'b0;
  endtask

  // Expected behaviour from the plan: a row ends at its last first-ack, one gap cycle
  // follows each non-final row, and TO consecutive event-free wait cycles raise err.
  task automatic build_model();
    int t, idle, end_c, lim;
    logic [NS-1:0] got_m, newb;
    bit fin;
    for (int i = 0; i < MAXT; i++) begin
      ack_at[i] = '0; det_at[i] = 1'b0; iv_at[i] = 1'b0;
      e_req[i] = 1'b0; e_idx[i] = '0; e_dst[i] = 1'b0; e_ov[i] = 1'b0;
      e_err[i] = 1'b0; e_fd[i] = 1'b0; e_gd[i] = '0; e_cnt[i] = '0;
    end
    t_err = 0; t_ds = 0; t_done = 0; t = 1; end_c = 0;
    for (int r = 0; r < ROWS && t_err == 0; r++) begin
      got_m = '0; idle = 0; fin = 1'b0;
      for (int o = 0; !fin && t_err == 0; o++) begin
        newb = '0;
        for (int s = 0; s < NS; s++) begin
          if (dly[r][s] == o) newb[s] = 1'b1;
          if (dup[r][s] == o) ack_at[t+o][s] = 1'b1;
        end
        ack_at[t+o] = ack_at[t+o] | newb;
        e_req[t+o] = 1'b1;
        e_idx[t+o] = RW'(r);
        if (noise && $urandom_range(0, 3) == 0) det_at[t+o] = 1'b1;
        if (newb != '0) idle = 0; else idle++;
        got_m = got_m | newb;
        if (&got_m) begin
          fin = 1'b1; end_c = t + o;
        end else if (idle == TO) begin
          t_err = t + o + 1;
        end
      end
      if (t_err == 0 && r < ROWS - 1) begin
        if (noise) ack_at[end_c+1] = NS'($urandom);
        t = end_c + 2;
      end
    end
    if (t_err == 0) begin
      t_ds = end_c + 1;
      e_dst[t_ds] = 1'b1;
      det_at[t_ds+det_k] = 1'b1;
      if (noise) for (int i = t_ds; i <= t_ds + det_k; i++) ack_at[i] = NS'($urandom);
      if (det_k - 1 >= TO) t_err = t_ds + TO + 1;
      else t_done = t_ds + det_k + 1;
    end
    for (int i = 0; i <= hold; i++) iv_at[i] = 1'b1;
    if (t_err != 0) begin
      t_end = t_err + 6;
      for (int i = t_err; i <= t_end; i++) iv_at[i] = 1'b1;
    end else begin
      t_end = ((t_done > hold + 1) ? t_done : hold + 1) + 3;
    end
    lim = (t_err != 0) ? t_err - 1 : t_done - 1;
    for (int i = 1; i <= t_end; i++) begin
      e_gd[i]  = (t_ds != 0 && i >= t_ds) ? {NS{1'b1}} : {NS{1'b0}};
      e_cnt[i] = CW'((i - 1 < lim) ? i - 1 : lim);
      if (t_err != 0) begin
        e_err[i] = (i >= t_err);
      end else begin
        e_fd[i] = (i >= t_done);
        e_ov[i] = (i == t_done);
      end
    end
  endtask

  task automatic drive_idle();
    bus.in_valid = 1'b0; bus.gauss_row_ack = '0; bus.det_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; drive_idle();
    #1; cur_t = -1;
    check_zero("rst");
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // rst_rel > 0 pulses rst that many cycles after det_start
  task automatic run_frame(input int rst_rel);
    int rst_at;
    build_model();
    rst_at = (rst_rel > 0) ? t_ds + rst_rel : -1;
    bus.in_valid = iv_at[0]; bus.gauss_row_ack = ack_at[0]; bus.det_done = det_at[0];
    for (int t = 1; t <= t_end; t++) begin
      @(posedge clk); #1; cur_t = t;
      if (t == rst_at) begin
        rst = 1'b1; drive_idle();
        #1; check_zero("abort");
        @(negedge clk); rst = 1'b0; bus.det_done = 1'b1;
        @(posedge clk); #1; bus.det_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
          check_zero("post_abort");
          @(posedge clk); #1;
        end
        return;
      end
      check_val("req", bus.gauss_row_req, e_req[t]);
      if (e_req[t]) check_val("idx", bus.gauss_row_idx, e_idx[t]);
      check_val("det_start", bus.det_start, e_dst[t]);
      check_val("out_valid", bus.out_valid, e_ov[t]);
      check_val("err", bus.err, e_err[t]);
      check_val("gauss_done", bus.gaussian_done, e_gd[t]);
      check_val("det_fdone", bus.detect_filter_done, e_fd[t]);
      check_val("cycle_cnt", bus.cycle_count, e_cnt[t]);
      bus.in_valid = iv_at[t]; bus.gauss_row_ack = ack_at[t]; bus.det_done = det_at[t];
    end
    drive_idle();
  endtask

  initial begin
    int maxd;
    rst = 1'b1; drive_idle();
    #12; cur_t = 0;
    check_zero("reset");
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check_zero("idle");

    plan_reset(0); det_k = 5; run_frame(0);
    plan_reset(0); dly[0][0] = 1; dly[0][1] = 3; dly[0][2] = 3; dly[0][3] = 7; dup[0][0] = 5;
    run_frame(0);
    plan_reset(0); dly[2][2] = -1; run_frame(0); do_reset();
    plan_reset(0); det_k = 10; run_frame(4);
    plan_reset(0); det_k = 1; run_frame(0);
    plan_reset(0); det_k = 3; hold = 40; run_frame(0); run_frame(0);
    plan_reset(0); det_k = 0; noise = 1'b1; run_frame(0);
    plan_reset(0); dly[1][3] = TO - 1; run_frame(0);
    plan_reset(0); dly[3][0] = TO; run_frame(0); do_reset();
    plan_reset(0); det_k = TO; run_frame(0);
    plan_reset(0); det_k = TO + 1; run_frame(0); do_reset();

    for (int f = 0; f < 20; f++) begin
      plan_reset(0);
      for (int r = 0; r < ROWS; r++) begin
        maxd = 0;
        for (int s = 0; s < NS; s++) begin
          dly[r][s] = ($urandom_range(0, 9) == 0) ? TO - 1 : $urandom_range(0, 5);
          if (dly[r][s] > maxd) maxd = dly[r][s];
        end
        for (int s = 0; s < NS; s++)
          if ($urandom_range(0, 2) == 0) dup[r][s] = $urandom_range(dly[r][s], maxd);
      end
      det_k = $urandom_range(0, 8);
      hold  = $urandom_range(0, 60);
      noise = 1'b1;
      run_frame(0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
